// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for a ROWS x COLS weight-stationary PE array.
// It loads weights when needed, streams the activation vectors, drains the
// array and then pulses done_o. It drives the PE mux codes and the feeder read
// strobes, and tracks when results become valid at the bottom of the array.

module systolic_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic                                   reuse_w_i,
  input  logic [VEC_W-1:0]                       num_vec_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   weights_valid_o,
  output logic                                   w_rd_o,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_row_o,
  output logic                                   a_rd_o,
  output logic [VEC_W-1:0]                       a_idx_o,
  output logic [2*ROWS-1:0]                      pe_mux_o,
  output logic [ROWS-1:0]                        add_zero_o,
  output logic [COLS-1:0]                        res_valid_o
);

  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PH_W   = $clog2(ROWS + COLS) + 1;
  localparam int PIPE_L = ROWS + COLS - 1;

  // Mux codes replicated across every PE row
  localparam logic [2*ROWS-1:0] MUX_SHIFT   = {ROWS{2'd0}};
  localparam logic [2*ROWS-1:0] MUX_LATCH   = {ROWS{2'd1}};
  localparam logic [2*ROWS-1:0] MUX_COMPUTE = {ROWS{2'd2}};
  localparam logic [2*ROWS-1:0] MUX_HOLD    = {ROWS{2'd3}};

  // Phase counter end values for the weight load and the drain
  localparam logic [PH_W-1:0]  W_LAST   = PH_W'(ROWS - 1);
  localparam logic [PH_W-1:0]  W_PEN    = PH_W'(ROWS - 2);
  localparam logic [PH_W-1:0]  D_LAST   = PH_W'(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [VEC_W-1:0]  n_vec;
  logic [PIPE_L-1:0] res_pipe;

  // Row 0 starts each column sum; the other rows accumulate from above
  assign add_zero_o = ROWS'(1);

  // Job sequencer; every output is registered alongside the state it belongs to
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      phase           <= '0;
      n_vec           <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      weights_valid_o <= 1'b0;
      w_rd_o          <= 1'b0;
      w_row_o         <= '0;
      a_rd_o          <= 1'b0;
      a_idx_o         <= '0;
      pe_mux_o        <= MUX_HOLD;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            n_vec  <= num_vec_i;
            busy_o <= 1'b1;
            if (reuse_w_i && weights_valid_o) begin
              if (num_vec_i != '0) begin
                state    <= STREAM;
                a_rd_o   <= 1'b1;
                a_idx_o  <= '0;
                pe_mux_o <= MUX_COMPUTE;
              end else begin
                state    <= DONE;
                done_o   <= 1'b1;
                pe_mux_o <= MUX_HOLD;
              end
            end else begin
              state    <= WLOAD;
              phase    <= '0;
              w_rd_o   <= 1'b1;
              w_row_o  <= ROW_LAST;
              pe_mux_o <= (ROWS == 1) ? MUX_LATCH : MUX_SHIFT;
            end
          end
        end

        WLOAD: begin
          if (phase == W_LAST) begin
            weights_valid_o <= 1'b1;
            w_rd_o          <= 1'b0;
            w_row_o         <= '0;
            phase           <= '0;
            if (n_vec != '0) begin
              state    <= STREAM;
              a_rd_o   <= 1'b1;
              a_idx_o  <= '0;
              pe_mux_o <= MUX_COMPUTE;
            end else begin
              state    <= DONE;
              done_o   <= 1'b1;
              pe_mux_o <= MUX_HOLD;
            end
          end else begin
            phase    <= phase + 1'b1;
            w_row_o  <= w_row_o - 1'b1;
            pe_mux_o <= (phase == W_PEN) ? MUX_LATCH : MUX_SHIFT;
          end
        end

        STREAM: begin
          if (a_idx_o == n_vec - VEC_W'(1)) begin
            state   <= DRAIN;
            a_rd_o  <= 1'b0;
            a_idx_o <= '0;
            phase   <= '0;
          end else begin
            a_idx_o <= a_idx_o + 1'b1;
          end
        end

        DRAIN: begin
          if (phase == D_LAST) begin
            state    <= DONE;
            done_o   <= 1'b1;
            pe_mux_o <= MUX_HOLD;
            phase    <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          pe_mux_o <= MUX_HOLD;
        end
      endcase
    end
  end

  // Delay line tracking each issued vector as it ripples through rows then columns
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_pipe <= '0;
    end else begin
      res_pipe[0] <= a_rd_o;
      for (int i = 1; i < PIPE_L; i++) begin
        res_pipe[i] <= res_pipe[i-1];
      end
    end
  end

  // Column c sees a vector ROWS+c cycles after it was issued
  for (genvar c = 0; c < COLS; c++) begin : g_res_valid
    assign res_valid_o[c] = res_pipe[ROWS+c-1];
  end

endmodule
